// File: rtl/regfile_dump.sv
// Read-side register-file dump engine: walks a wrapping address range, reads each
// register through one read port and streams {address, data} over valid/ready.
module regfile_dump #(
   parameter int ADDR_SIZE = 5,
   parameter int DATA_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 rstb,
   input  logic                 start,
   input  logic [ADDR_SIZE-1:0] first_addr,
   input  logic [ADDR_SIZE-1:0] last_addr,
   output logic [ADDR_SIZE-1:0] rf_rd_addr,
   input  logic [DATA_SIZE-1:0] rf_rd_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ADDR_SIZE-1:0] out_addr,
   output logic [DATA_SIZE-1:0] out_data,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [ADDR_SIZE-1:0] r_rd_addr;
   logic [ADDR_SIZE-1:0] r_end_addr;
   logic [ADDR_SIZE-1:0] r_out_addr;
   logic [DATA_SIZE-1:0] r_out_data;
   logic                 r_out_valid;
   logic                 r_done;

   logic w_slot_free;
   logic w_capture;
   logic w_at_end;
   logic w_drain_hs;

   // The output slot can take a new word if it is empty or being drained this cycle.
   assign w_slot_free = !r_out_valid || out_ready;
   assign w_capture   = (r_state == SCAN) && w_slot_free;
   assign w_at_end    = (r_rd_addr == r_end_addr);
   assign w_drain_hs  = (r_state == DRAIN) && r_out_valid && out_ready;

   // NOTE: reset is sampled only on the clock edge, so it sits inside the
   // edge-triggered block rather than in the sensitivity list.
   always_ff @(posedge clk) begin
      if (!rstb) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   // NOTE: a default assignment first keeps every path assigned, so no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         IDLE:    if (start)                 w_next_state = SCAN;
         SCAN:    if (w_capture && w_at_end) w_next_state = DRAIN;
         DRAIN:   if (w_drain_hs)            w_next_state = IDLE;
         default:                            w_next_state = IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state != IDLE);
      done = r_done;
   end

   // NOTE: all state here uses non-blocking assignments so every register samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         r_rd_addr   <= '0;
         r_end_addr  <= '0;
         r_out_addr  <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if ((r_state == IDLE) && start) begin
            r_rd_addr  <= first_addr;
            r_end_addr <= last_addr;
         end
         if (w_capture) begin
            r_out_data  <= rf_rd_data;
            r_out_addr  <= r_rd_addr;
            r_out_valid <= 1'b1;
            if (!w_at_end) r_rd_addr <= r_rd_addr + ADDR_SIZE'(1);
         end
         if (w_drain_hs) begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
         end
      end
   end

   assign rf_rd_addr = r_rd_addr;
   assign out_valid  = r_out_valid;
   assign out_addr   = r_out_addr;
   assign out_data   = r_out_data;

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: a behavioural register file feeds the read port,
// expected words are queued at start and popped at each observed handshake.
module tb_regfile_dump;

   localparam int AW   = 5;
   localparam int DW   = 32;
   localparam int NREG = 32;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } word_t;

   logic          clk = 1'b0;
   logic          rstb = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] first_addr = '0;
   logic [AW-1:0] last_addr = '0;
   logic [AW-1:0] rf_rd_addr;
   logic [DW-1:0] rf_rd_data;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [AW-1:0] out_addr;
   logic [DW-1:0] out_data;
   logic          busy;
   logic          done;

   logic [DW-1:0] regs [NREG];
   assign rf_rd_data = regs[rf_rd_addr];

   regfile_dump #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
      .clk        (clk),
      .rstb       (rstb),
      .start      (start),
      .first_addr (first_addr),
      .last_addr  (last_addr),
      .rf_rd_addr (rf_rd_addr),
      .rf_rd_data (rf_rd_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_addr   (out_addr),
      .out_data   (out_data),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int    n_tests = 0;
   int    n_fail = 0;
   int    cyc = 0;
   word_t exp_q[$];
   word_t exp_w;

   always @(posedge clk) cyc <= cyc + 1;

   // Downstream ready: 0 = always ready, 1 = fixed toggle pattern, 2 = random.
   int ready_mode = 0;
   int rdy_idx = 0;
   bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         1:       begin out_ready = pat[rdy_idx % 6]; rdy_idx++; end
         2:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b1;
      endcase
   end

   // Stream monitor: stability under stall, scoreboard at handshake, done pulse shape.
   bit            mon_en = 1'b1;
   int            n_hs = 0;
   int            n_done = 0;
   int            last_hs_cyc = 0;
   int            first_hs_cyc = 0;
   bit            got_first = 1'b0;
   logic          prev_stall = 1'b0;
   logic          prev_done = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic [DW-1:0] prev_data = '0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (prev_stall) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_addr !== prev_addr || out_data !== prev_data) begin
               n_fail++;
               $display("FAIL stall_hold: got v=%b a=%0d d=%h, need v=1 a=%0d d=%h",
                        out_valid, out_addr, out_data, prev_addr, prev_data);
            end
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_word: got a=%0d d=%h, need no word", out_addr, out_data);
            end else begin
               exp_w = exp_q.pop_front();
               if (out_addr !== exp_w.addr || out_data !== exp_w.data) begin
                  n_fail++;
                  $display("FAIL word: got a=%0d d=%h, need a=%0d d=%h",
                           out_addr, out_data, exp_w.addr, exp_w.data);
               end
            end
            n_hs++;
            last_hs_cyc = cyc;
            if (!got_first) begin
               got_first    = 1'b1;
               first_hs_cyc = cyc;
            end
         end
         if (done === 1'b1) begin
            n_done++;
            n_tests++;
            if (busy !== 1'b0 || cyc != last_hs_cyc + 1 || exp_q.size() != 0 || prev_done === 1'b1) begin
               n_fail++;
               $display("FAIL done_pulse: got busy=%b dcyc=%0d left=%0d prev=%b, need busy=0 dcyc=1 left=0 prev=0",
                        busy, cyc - last_hs_cyc, exp_q.size(), prev_done);
            end
         end
         prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
         prev_addr  = out_addr;
         prev_data  = out_data;
         prev_done  = done;
      end else begin
         prev_stall = 1'b0;
         prev_done  = 1'b0;
      end
   end

   task automatic push_range(input logic [AW-1:0] f, input logic [AW-1:0] l,
                             input bit ovr, input logic [AW-1:0] oa, input logic [DW-1:0] od);
      int            n;
      logic [AW-1:0] a;
      word_t         w;
      n = int'(AW'(l - f)) + 1;
      for (int i = 0; i < n; i++) begin
         a      = f + AW'(i);
         w.addr = a;
         w.data = (ovr && a == oa) ? od : regs[a];
         exp_q.push_back(w);
      end
   endtask

   task automatic pulse_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
      @(negedge clk);
      first_addr = f;
      last_addr  = l;
      start      = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int done_before, input int budget, input string name);
      int k = 0;
      while (n_done == done_before && k < budget) begin
         @(posedge clk);
         k++;
      end
      @(negedge clk);
      n_tests++;
      if (n_done != done_before + 1) begin
         n_fail++;
         $display("FAIL %s_done_count: got %0d, need %0d", name, n_done - done_before, 1);
      end
   endtask

   task automatic test_reset;
      rstb = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({out_valid, busy, done, rf_rd_addr, out_addr, out_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got v=%b b=%b d=%b ra=%0d oa=%0d od=%h, need all 0",
                  out_valid, busy, done, rf_rd_addr, out_addr, out_data);
      end
      rstb = 1'b1;
   endtask

   task automatic test_full_dump;
      int d0 = n_done;
      ready_mode = 0;
      push_range(5'd0, 5'd31, 1'b0, '0, '0);
      got_first = 1'b0;
      pulse_start(5'd0, 5'd31);
      n_tests++;
      if (busy !== 1'b1 || rf_rd_addr !== 5'd0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL full_latency1: got b=%b ra=%0d v=%b, need b=1 ra=0 v=0", busy, rf_rd_addr, out_valid);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL full_latency2: got v=%b, need v=1", out_valid);
      end
      wait_done(d0, 100, "full");
      n_tests++;
      if (last_hs_cyc - first_hs_cyc != 31 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL full_rate: got span=%0d busy=%b, need span=31 busy=0", last_hs_cyc - first_hs_cyc, busy);
      end
   endtask

   task automatic test_backpressure;
      int d0 = n_done;
      int h0 = n_hs;
      ready_mode = 1;
      rdy_idx    = 0;
      push_range(5'd4, 5'd7, 1'b0, '0, '0);
      pulse_start(5'd4, 5'd7);
      wait_done(d0, 100, "bp");
      n_tests++;
      if (n_hs - h0 != 4) begin
         n_fail++;
         $display("FAIL bp_count: got %0d, need 4", n_hs - h0);
      end
      ready_mode = 0;
   endtask

   task automatic test_wrap_single;
      int d0 = n_done;
      int h0 = n_hs;
      ready_mode = 0;
      push_range(5'd30, 5'd1, 1'b0, '0, '0);
      pulse_start(5'd30, 5'd1);
      wait_done(d0, 50, "wrap");
      n_tests++;
      if (n_hs - h0 != 4) begin
         n_fail++;
         $display("FAIL wrap_count: got %0d, need 4", n_hs - h0);
      end
      d0 = n_done;
      h0 = n_hs;
      push_range(5'd9, 5'd9, 1'b0, '0, '0);
      pulse_start(5'd9, 5'd9);
      wait_done(d0, 50, "single");
      n_tests++;
      if (n_hs - h0 != 1) begin
         n_fail++;
         $display("FAIL single_count: got %0d, need 1", n_hs - h0);
      end
   endtask

   task automatic test_start_busy;
      int d0 = n_done;
      ready_mode = 2;
      push_range(5'd10, 5'd20, 1'b0, '0, '0);
      pulse_start(5'd10, 5'd20);
      repeat (3) @(posedge clk);
      pulse_start(5'd0, 5'd3);
      wait_done(d0, 300, "busy_start");
      ready_mode = 0;
      repeat (10) @(posedge clk);
      #1;
      n_tests++;
      if (n_done != d0 + 1 || busy !== 1'b0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL busy_start_after: got dones=%0d busy=%b left=%0d, need dones=1 busy=0 left=0",
                  n_done - d0, busy, exp_q.size());
      end
   endtask

   task automatic test_reset_mid;
      int d0 = n_done;
      int h0 = n_hs;
      int k = 0;
      ready_mode = 0;
      push_range(5'd0, 5'd31, 1'b0, '0, '0);
      pulse_start(5'd0, 5'd31);
      while (n_hs < h0 + 3 && k < 50) begin
         @(posedge clk);
         k++;
      end
      #1;
      mon_en = 1'b0;
      rstb   = 1'b0;
      @(posedge clk);
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || rf_rd_addr !== '0 || out_data !== '0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: got v=%b b=%b ra=%0d od=%h d=%b, need all 0",
                  out_valid, busy, rf_rd_addr, out_data, done);
      end
      rstb = 1'b1;
      exp_q.delete();
      mon_en = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      n_tests++;
      if (n_done != d0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_nodone: got dones=%0d busy=%b, need dones=0 busy=0", n_done - d0, busy);
      end
      d0 = n_done;
      push_range(5'd3, 5'd6, 1'b0, '0, '0);
      pulse_start(5'd3, 5'd6);
      wait_done(d0, 50, "after_reset");
   endtask

   task automatic test_concurrent_write;
      int            d0 = n_done;
      int            k = 0;
      logic [DW-1:0] saved;
      saved      = regs[5];
      ready_mode = 0;
      push_range(5'd2, 5'd8, 1'b1, 5'd5, 32'hDEAD_BEEF);
      pulse_start(5'd2, 5'd8);
      while (rf_rd_addr !== 5'd5 && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      n_tests++;
      if (rf_rd_addr !== 5'd5) begin
         n_fail++;
         $display("FAIL cw_reach: got ra=%0d, need 5", rf_rd_addr);
      end
      @(negedge clk);
      regs[5] = 32'hDEAD_BEEF;
      wait_done(d0, 50, "cw");
      regs[5] = saved;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, need finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < NREG; i++) regs[i] = 32'hA500_0000 + i;
      test_reset;
      test_full_dump;
      test_backpressure;
      test_wrap_single;
      test_start_busy;
      test_reset_mid;
      test_concurrent_write;
      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
